sdio_clk_gen: RTL and testbench
===============================

# sdio_clk_gen

Parametrised SD-bus clock generator for the SD/FAT32 path. It derives the card clock from the 48 MHz system clock with a runtime-programmable divider and changes frequency without glitches. It also parks the clock low on request and can emit an exact burst of clock periods, such as the 74+ initialisation clocks. It produces single-cycle rise/fall strobes so that command/data logic stays in the 48 MHz domain instead of clocking flops from a divided clock.

## Interface
- DIV_W, 8: width of divider input and internal half-period counter
- DIV_INIT, 59: divider value loaded at reset (400 kHz at 48 MHz)
- BURST_W, 8: width of burst length / remaining-edge counter
- clk48mhz  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- clk_en  in  1  level; 1 = run continuously, 0 = stop at next low-phase end
- div  in  DIV_W  half-period minus 1; sdio_clk period = 2*(div+1) clk48mhz cycles
- burst_start  in  1  one-cycle pulse; start burst of burst_len rising edges
- burst_len  in  BURST_W  rising edges in burst, sampled with burst_start
- sdio_clk  out  1  registered card clock
- clk_rise  out  1  high for the one cycle in which sdio_clk first reads 1
- clk_fall  out  1  high for the one cycle in which sdio_clk first reads 0 after high
- div_ack  out  1  one-cycle pulse when div is latched into div_q
- clk_running  out  1  state != IDLE
- burst_busy  out  1  burst in progress
- burst_done  out  1  one-cycle pulse at clk_fall ending the last burst period

## Operation
- States: IDLE (sdio_clk=0, counter held), LOW, HIGH. Counter cnt counts 0..div_q, then resets to 0 on a phase change.
- IDLE -> LOW when run = clk_en | burst_busy is sampled 1. On that transition: div_q <= div, div_ack pulses, cnt <= 0.
- LOW, cnt==div_q:
  - run=1: -> HIGH, sdio_clk <= 1, clk_rise=1. If the burst is active, burst_rem decrements.
  - run=0: -> IDLE. No edge.
- HIGH, cnt==div_q: -> LOW unconditionally. sdio_clk <= 0, clk_fall=1, div_q <= div, div_ack pulses.
- Glitch-free rules:
  - A high phase always completes.
  - The clock only ever stops low.
  - A divider change takes effect only at a low-phase start, so each full period uses one div_q value.
- Burst:
  - burst_start with burst_busy=0 and burst_len!=0 loads burst_rem <= burst_len and sets burst_busy.
  - burst_done pulses with the clk_fall that follows the rising edge taking burst_rem to 0. burst_busy clears in the same cycle.
  - burst_start while busy is ignored. burst_len==0 is ignored (no busy, no done).
- clk_en=1 during a burst: the clock keeps running after burst_done; the burst still counts and reports exactly.
- clk_en deasserted mid-high-phase: the high phase finishes, the low phase finishes, then IDLE.

## Timing
- Reset values: sdio_clk, clk_rise, clk_fall, div_ack, clk_running, burst_busy, burst_done = 0. State=IDLE, cnt=0, div_q=DIV_INIT, burst_rem=0.
- Reset mid-operation: sdio_clk is 0 from the first cycle after the reset edge. Any burst is abandoned with no burst_done.
- First rising edge: sdio_clk reads 1 exactly div+2 cycles after the cycle in which run is first sampled 1 in IDLE.
- Period is 2*(div+1) cycles with 50% duty. div=0 gives 24 MHz; div=119 gives 200 kHz.
- Strobes are registered alongside sdio_clk (zero skew between strobe and edge).
- cnt width DIV_W; the comparison is equality only. div must not be altered mid-phase to rely on; it is sampled only at latch points.

## Structure
- Package sdio_clk_pkg:
  - state enum {IDLE, LOW, HIGH}
  - DIV_W default
  - constants DIV_400K=59, DIV_200K=119, DIV_24M=0, INIT_CLKS=80
- Single module, no sub-module. The counter and burst logic are small enough to inline.

## Test plan
- Reset, then clk_en=1, div=0 -> first sdio_clk=1 at cycle 2 after enable; period 2; clk_rise/clk_fall alternate every cycle.
- div=59, run 3 periods, then set div=0 mid-high-phase -> current period remains 120 cycles; the next low phase is 1 cycle; div_ack pulses at that fall.
- clk_en=0 asserted in the first cycle of a high phase (div=3) -> high lasts 4 cycles, low 4, then clk_running=0 and sdio_clk stays 0.
- burst_start, burst_len=80, clk_en=0, div=119 -> exactly 80 clk_rise pulses, burst_done at the 80th clk_fall, clock idle afterwards; a second burst_start while busy has no effect.
- rst asserted while sdio_clk=1 during a burst -> next cycle sdio_clk=0, burst_busy=0, div_q=59, no burst_done.
- burst_len=0 -> no clock edges, burst_busy and burst_done stay 0.

Source files
------------

// File: rtl/sdio_clk_gen_pkg.sv
// sdio_clk_pkg: shared types and constants for the SD-bus clock generator.
//   state_e      - clock generator phase: IDLE (parked low), LOW, HIGH
//   DIV_W_DEF    - default width of the divider / half-period counter
//   DIV_*        - divider values for the common SD bus rates at 48 MHz
//   INIT_CLKS    - burst length used for the card power-up clock train
package sdio_clk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_e;

  localparam int DIV_W_DEF = 8;

  // sdio_clk period = 2*(div+1) cycles of the 48 MHz clock
  localparam int DIV_400K  = 59;
  localparam int DIV_200K  = 119;
  localparam int DIV_24M   = 0;

  // Comfortably above the 74 clocks a card needs before its first command
  localparam int INIT_CLKS = 80;

endpackage

// File: rtl/sdio_clk_gen_if.sv
// sdio_clk_gen_if: control/status bundle of the SD-bus clock generator.
//   Controls (master -> slave): clk_en, div, burst_start, burst_len
//   Status   (slave -> master): sdio_clk, clk_rise, clk_fall, div_ack,
//                               clk_running, burst_busy, burst_done
//   Debug    (slave -> master): dbg_state, dbg_div_q
//
// Handshake semantics: there is no valid/ready pair here. clk_en and div
// are levels; div is only sampled on a cycle in which div_ack is high.
// burst_start is a one-cycle request, accepted only when burst_busy is 0
// and burst_len is non-zero; it has no acknowledge other than burst_busy
// rising on the next cycle.
interface sdio_clk_gen_if #(
  parameter int DIV_W   = 8,
  parameter int BURST_W = 8
);
  import sdio_clk_pkg::*;

  logic               clk_en;
  logic [DIV_W-1:0]   div;
  logic               burst_start;
  logic [BURST_W-1:0] burst_len;

  logic               sdio_clk;
  logic               clk_rise;
  logic               clk_fall;
  logic               div_ack;
  logic               clk_running;
  logic               burst_busy;
  logic               burst_done;

  state_e             dbg_state;
  logic [DIV_W-1:0]   dbg_div_q;

  modport slave (
    input  clk_en, div, burst_start, burst_len,
    output sdio_clk, clk_rise, clk_fall, div_ack, clk_running,
           burst_busy, burst_done, dbg_state, dbg_div_q
  );

  modport master (
    output clk_en, div, burst_start, burst_len,
    input  sdio_clk, clk_rise, clk_fall, div_ack, clk_running,
           burst_busy, burst_done, dbg_state, dbg_div_q
  );

endinterface

// File: rtl/sdio_clk_gen.sv
// sdio_clk_gen: glitch-free SD card clock generator in the 48 MHz domain.
//   clk48mhz  - system clock, every flop on its rising edge
//   rst       - synchronous, active-high reset
//   bus       - control/status bundle (sdio_clk_gen_if.slave):
//     clk_en      level, keep the clock running
//     div         half-period minus 1, latched only when div_ack pulses
//     burst_start one-cycle request for burst_len rising edges
//     sdio_clk    registered card clock
//     clk_rise    first cycle sdio_clk reads 1
//     clk_fall    first cycle sdio_clk reads 0 after a high phase
//     div_ack     div was latched into div_q this cycle
//     clk_running state is not IDLE
//     burst_busy  burst in progress
//     burst_done  pulse on the clk_fall closing the last burst period
//     dbg_state / dbg_div_q  internal state for observation
//
// The clock only ever stops in its low phase, a started high phase always
// completes, and the divider is only reloaded at the start of a low phase,
// so every full period is built from a single div_q value.
module sdio_clk_gen
  import sdio_clk_pkg::*;
#(
  parameter int DIV_W    = DIV_W_DEF,
  parameter int DIV_INIT = DIV_400K,
  parameter int BURST_W  = 8
) (
  input  logic         clk48mhz,
  input  logic         rst,
  sdio_clk_gen_if.slave bus
);

  state_e             state_q,       state_d;
  logic [DIV_W-1:0]   cnt_q,         cnt_d;
  logic [DIV_W-1:0]   div_q,         div_d;
  logic [BURST_W-1:0] burst_rem_q,   burst_rem_d;
  logic               burst_busy_q,  burst_busy_d;
  logic               sdio_clk_q,    sdio_clk_d;
  logic               clk_rise_q,    clk_rise_d;
  logic               clk_fall_q,    clk_fall_d;
  logic               div_ack_q,     div_ack_d;
  logic               clk_running_q, clk_running_d;
  logic               burst_done_q,  burst_done_d;

  logic               run;
  logic               phase_end;

  // A pending burst keeps the clock alive even with clk_en low.
  assign run       = bus.clk_en | burst_busy_q;
  assign phase_end = (cnt_q == div_q);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    div_d         = div_q;
    burst_rem_d   = burst_rem_q;
    burst_busy_d  = burst_busy_q;
    sdio_clk_d    = sdio_clk_q;
    clk_rise_d    = 1'b0;
    clk_fall_d    = 1'b0;
    div_ack_d     = 1'b0;
    burst_done_d  = 1'b0;

    // Burst request is accepted only when idle-of-burst and non-empty.
    // It can never collide with the decrement/clear below, which only
    // happen while burst_busy_q is already set.
    if (bus.burst_start && !burst_busy_q && (bus.burst_len != '0)) begin
      burst_rem_d  = bus.burst_len;
      burst_busy_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d      = '0;
        sdio_clk_d = 1'b0;
        if (run) begin
          state_d   = LOW;
          div_d     = bus.div;
          div_ack_d = 1'b1;
        end
      end

      LOW: begin
        if (phase_end) begin
          cnt_d = '0;
          if (run) begin
            state_d    = HIGH;
            sdio_clk_d = 1'b1;
            clk_rise_d = 1'b1;
            if (burst_busy_q) begin
              burst_rem_d = burst_rem_q - 1'b1;
            end
          end else begin
            // Stopping at the end of a low phase keeps the clock parked low
            // without shortening any pulse.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      HIGH: begin
        if (phase_end) begin
          state_d    = LOW;
          cnt_d      = '0;
          sdio_clk_d = 1'b0;
          clk_fall_d = 1'b1;
          div_d      = bus.div;
          div_ack_d  = 1'b1;
          // The rising edge that drained burst_rem has now completed its
          // period, so the burst is reported finished on this fall.
          if (burst_busy_q && (burst_rem_q == '0)) begin
            burst_done_d = 1'b1;
            burst_busy_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      default: begin
        state_d    = IDLE;
        cnt_d      = '0;
        sdio_clk_d = 1'b0;
      end
    endcase

    clk_running_d = (state_d != IDLE);
  end

  always_ff @(posedge clk48mhz) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      div_q         <= DIV_W'(DIV_INIT);
      burst_rem_q   <= '0;
      burst_busy_q  <= 1'b0;
      sdio_clk_q    <= 1'b0;
      clk_rise_q    <= 1'b0;
      clk_fall_q    <= 1'b0;
      div_ack_q     <= 1'b0;
      clk_running_q <= 1'b0;
      burst_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_q         <= div_d;
      burst_rem_q   <= burst_rem_d;
      burst_busy_q  <= burst_busy_d;
      sdio_clk_q    <= sdio_clk_d;
      clk_rise_q    <= clk_rise_d;
      clk_fall_q    <= clk_fall_d;
      div_ack_q     <= div_ack_d;
      clk_running_q <= clk_running_d;
      burst_done_q  <= burst_done_d;
    end
  end

  assign bus.sdio_clk    = sdio_clk_q;
  assign bus.clk_rise    = clk_rise_q;
  assign bus.clk_fall    = clk_fall_q;
  assign bus.div_ack     = div_ack_q;
  assign bus.clk_running = clk_running_q;
  assign bus.burst_busy  = burst_busy_q;
  assign bus.burst_done  = burst_done_q;
  assign bus.dbg_state   = state_q;
  assign bus.dbg_div_q   = div_q;

endmodule

// File: tb/tb_sdio_clk_gen.sv
// tb_sdio_clk_gen: directed bench for sdio_clk_gen.
module tb_sdio_clk_gen;
  import sdio_clk_pkg::*;

  localparam int MAX_WAIT = 1000;

  // ---------------- clock / reset ----------------
  logic clk48mhz = 1'b0;
  logic rst      = 1'b1;
  always #5 clk48mhz = ~clk48mhz;

  sdio_clk_gen_if #(.DIV_W(8), .BURST_W(8)) bus ();

  sdio_clk_gen #(.DIV_W(8), .DIV_INIT(59), .BURST_W(8)) dut (
    .clk48mhz (clk48mhz),
    .rst      (rst),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk48mhz);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic hit(input int sel);
    case (sel)
      0:       return bus.clk_rise;
      1:       return bus.clk_fall;
      2:       return !bus.clk_running;
      default: return bus.burst_done;
    endcase
  endfunction

  // Ticks until the selected event; -1 if it never appears within MAX_WAIT.
  task automatic wait_ev(input int sel, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!hit(sel) && n < MAX_WAIT);
    if (!hit(sel)) n = -1;
  endtask

  initial begin
    int n;
    int rises;
    int dones;
    int fall_at_done;
    int busy_at_done;

    bus.clk_en      = 1'b0;
    bus.div         = 8'd0;
    bus.burst_start = 1'b0;
    bus.burst_len   = 8'd0;

    // ---- reset values ----
    tick();
    tick();
    rst = 1'b0;
    check("rst_sdio_clk",    32'(bus.sdio_clk),    32'd0);
    check("rst_clk_rise",    32'(bus.clk_rise),    32'd0);
    check("rst_clk_fall",    32'(bus.clk_fall),    32'd0);
    check("rst_div_ack",     32'(bus.div_ack),     32'd0);
    check("rst_clk_running", 32'(bus.clk_running), 32'd0);
    check("rst_burst_busy",  32'(bus.burst_busy),  32'd0);
    check("rst_burst_done",  32'(bus.burst_done),  32'd0);
    check("rst_state",       32'(bus.dbg_state),   32'(IDLE));
    check("rst_div_q",       32'(bus.dbg_div_q),   32'd59);

    // ---- div=0: first rise 2 cycles after enable, then 24 MHz ----
    bus.clk_en = 1'b1;
    bus.div    = 8'd0;
    tick();
    check("d0_start_ack",     32'(bus.div_ack),     32'd1);
    check("d0_start_running", 32'(bus.clk_running), 32'd1);
    check("d0_start_sdio",    32'(bus.sdio_clk),    32'd0);
    check("d0_start_div_q",   32'(bus.dbg_div_q),   32'd0);
    tick();
    check("d0_first_sdio", 32'(bus.sdio_clk), 32'd1);
    check("d0_first_rise", 32'(bus.clk_rise), 32'd1);
    tick();
    check("d0_fall_sdio", 32'(bus.sdio_clk), 32'd0);
    check("d0_fall_fall", 32'(bus.clk_fall), 32'd1);
    check("d0_fall_ack",  32'(bus.div_ack),  32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("d0_alt_sdio", 32'(bus.sdio_clk), 32'(i % 2 == 0));
      check("d0_alt_rise", 32'(bus.clk_rise), 32'(i % 2 == 0));
      check("d0_alt_fall", 32'(bus.clk_fall), 32'(i % 2 != 0));
    end
    bus.clk_en = 1'b0;
    wait_ev(2, n);
    check("d0_stop_idle", 32'(n > 0), 32'd1);

    // ---- div=59: three periods, then div change mid-high ----
    bus.div    = 8'd59;
    bus.clk_en = 1'b1;
    wait_ev(0, n); check("d59_first_rise", 32'(n), 32'd61);
    wait_ev(1, n); check("d59_high",       32'(n), 32'd60);
    wait_ev(0, n); check("d59_low",        32'(n), 32'd60);
    wait_ev(1, n); check("d59_high2",      32'(n), 32'd60);
    wait_ev(0, n); check("d59_low2",       32'(n), 32'd60);
    wait_ev(1, n); check("d59_high3",      32'(n), 32'd60);
    wait_ev(0, n); check("d59_low3",       32'(n), 32'd60);
    repeat (10) tick();
    bus.div = 8'd0;
    wait_ev(1, n);
    check("chg_high_rest", 32'(n),             32'd50);
    check("chg_ack",       32'(bus.div_ack),   32'd1);
    check("chg_div_q",     32'(bus.dbg_div_q), 32'd0);
    wait_ev(0, n); check("chg_low_1cyc",  32'(n), 32'd1);
    wait_ev(1, n); check("chg_high_1cyc", 32'(n), 32'd1);

    // ---- div=3, clk_en dropped in the first high cycle ----
    bus.div = 8'd3;
    wait_ev(1, n);
    check("d3_div_q", 32'(bus.dbg_div_q), 32'd3);
    wait_ev(0, n); check("d3_low", 32'(n), 32'd4);
    bus.clk_en = 1'b0;
    wait_ev(1, n); check("stop_high_len", 32'(n), 32'd4);
    wait_ev(2, n); check("stop_low_len",  32'(n), 32'd4);
    check("stop_sdio",  32'(bus.sdio_clk),  32'd0);
    check("stop_state", 32'(bus.dbg_state), 32'(IDLE));
    rises = 0;
    repeat (20) begin
      tick();
      if (bus.clk_rise || bus.sdio_clk) rises++;
    end
    check("stop_parked", 32'(rises), 32'd0);

    // ---- 80-clock init burst at div=119, second start ignored ----
    bus.div         = 8'd119;
    bus.burst_len   = 8'd80;
    bus.burst_start = 1'b1;
    tick();
    bus.burst_start = 1'b0;
    check("burst_busy_set", 32'(bus.burst_busy), 32'd1);
    rises = 0; dones = 0; fall_at_done = 0; busy_at_done = 1;
    for (int i = 0; i < 25000; i++) begin
      bus.burst_start = (i == 500);
      bus.burst_len   = (i == 500) ? 8'd5 : 8'd80;
      tick();
      if (bus.clk_rise) rises++;
      if (bus.burst_done) begin
        dones++;
        fall_at_done = bus.clk_fall;
        busy_at_done = bus.burst_busy;
        check("burst_rises_at_done", 32'(rises), 32'd80);
      end
      if (dones > 0 && !bus.clk_running) break;
    end
    bus.burst_start = 1'b0;
    check("burst_rises_total", 32'(rises),           32'd80);
    check("burst_done_count",  32'(dones),           32'd1);
    check("burst_done_w_fall", 32'(fall_at_done),    32'd1);
    check("burst_busy_clear",  32'(busy_at_done),    32'd0);
    check("burst_idle_after",  32'(bus.clk_running), 32'd0);
    check("burst_sdio_after",  32'(bus.sdio_clk),    32'd0);

    // ---- reset while sdio_clk is high during a burst ----
    bus.div         = 8'd3;
    bus.burst_len   = 8'd10;
    bus.burst_start = 1'b1;
    tick();
    bus.burst_start = 1'b0;
    wait_ev(0, n);
    check("rstmid_rise_seen", 32'(n > 0), 32'd1);
    rst = 1'b1;
    tick();
    check("rstmid_sdio",  32'(bus.sdio_clk),   32'd0);
    check("rstmid_busy",  32'(bus.burst_busy), 32'd0);
    check("rstmid_div_q", 32'(bus.dbg_div_q),  32'd59);
    check("rstmid_done",  32'(bus.burst_done), 32'd0);
    rst = 1'b0;
    dones = 0; rises = 0;
    repeat (50) begin
      tick();
      if (bus.burst_done) dones++;
      if (bus.clk_rise) rises++;
    end
    check("rstmid_no_done", 32'(dones), 32'd0);
    check("rstmid_no_rise", 32'(rises), 32'd0);

    // ---- burst_len=0 is ignored ----
    bus.burst_len   = 8'd0;
    bus.burst_start = 1'b1;
    tick();
    bus.burst_start = 1'b0;
    check("len0_busy", 32'(bus.burst_busy), 32'd0);
    dones = 0; rises = 0;
    repeat (50) begin
      tick();
      if (bus.burst_done || bus.burst_busy) dones++;
      if (bus.clk_rise || bus.sdio_clk) rises++;
    end
    check("len0_no_done", 32'(dones), 32'd0);
    check("len0_no_edge", 32'(rises), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
